// File: rtl/alu_result_checker.sv
// Execute-stage ALU result checker: recomputes result and NZCV from the ALU input bundle,
// compares against the ALU outputs, and keeps saturating statistics plus first-failure capture.
module alu_result_checker #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned CNT_W          = 16,
  parameter bit          CHECK_CV_LOGIC = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [3:0]       exe_cmd,
  input  logic             c_in,
  input  logic [WIDTH-1:0] dut_out,
  input  logic [3:0]       dut_status,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic             illegal_cmd,
  output logic             sticky_err,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       first_err_cmd,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got,
  output logic [7:0]       first_err_flags
);

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } alu_cmd_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_val1;
  logic [WIDTH-1:0] s1_val2;
  logic [3:0]       s1_cmd;
  logic             s1_cin;
  logic [WIDTH-1:0] s1_dut_out;
  logic [3:0]       s1_dut_status;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid      <= 1'b0;
      s1_val1       <= '0;
      s1_val2       <= '0;
      s1_cmd        <= '0;
      s1_cin        <= 1'b0;
      s1_dut_out    <= '0;
      s1_dut_status <= '0;
    end else begin
      s1_valid      <= in_valid;
      s1_val1       <= val1;
      s1_val2       <= val2;
      s1_cmd        <= exe_cmd;
      s1_cin        <= c_in;
      s1_dut_out    <= dut_out;
      s1_dut_status <= dut_status;
    end
  end

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] add_b;
  logic             add_ci;
  logic             is_arith;
  logic             legal;
  logic [WIDTH-1:0] exp_res;
  logic [3:0]       exp_flags;
  logic [3:0]       cmp_mask;
  logic             mismatch;

  // All four arithmetic commands share one WIDTH+1-bit adder; SUB/SBC feed ~val2,
  // so the carry-out is the inverted borrow.
  always_comb begin
    add_b    = s1_val2;
    add_ci   = 1'b0;
    is_arith = 1'b0;
    legal    = 1'b1;
    exp_res  = '0;
    case (s1_cmd)
      CMD_ADD: is_arith = 1'b1;
      CMD_ADC: begin is_arith = 1'b1; add_ci = s1_cin; end
      CMD_SUB: begin is_arith = 1'b1; add_b = ~s1_val2; add_ci = 1'b1; end
      CMD_SBC: begin is_arith = 1'b1; add_b = ~s1_val2; add_ci = s1_cin; end
      default: ;
    endcase
    sum = {1'b0, s1_val1} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};
    case (s1_cmd)
      CMD_MOV:                           exp_res = s1_val2;
      CMD_MVN:                           exp_res = ~s1_val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: exp_res = sum[WIDTH-1:0];
      CMD_AND:                           exp_res = s1_val1 & s1_val2;
      CMD_ORR:                           exp_res = s1_val1 | s1_val2;
      CMD_EOR:                           exp_res = s1_val1 ^ s1_val2;
      default:                           legal   = 1'b0;
    endcase
    exp_flags[3] = exp_res[WIDTH-1];
    exp_flags[2] = (exp_res == '0);
    exp_flags[1] = is_arith & sum[WIDTH];
    exp_flags[0] = is_arith & (s1_val1[WIDTH-1] == add_b[WIDTH-1])
                            & (sum[WIDTH-1] != s1_val1[WIDTH-1]);
    cmp_mask = (is_arith || CHECK_CV_LOGIC) ? 4'b1111 : 4'b1100;
    mismatch = (exp_res != s1_dut_out) || (((exp_flags ^ s1_dut_status) & cmp_mask) != 4'b0000);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_valid       <= 1'b0;
      chk_pass        <= 1'b0;
      illegal_cmd     <= 1'b0;
      sticky_err      <= 1'b0;
      check_count     <= '0;
      err_count       <= '0;
      first_err_cmd   <= '0;
      first_err_exp   <= '0;
      first_err_got   <= '0;
      first_err_flags <= '0;
    end else begin
      chk_valid   <= s1_valid;
      chk_pass    <= s1_valid & legal & ~mismatch;
      illegal_cmd <= s1_valid & ~legal;
      if (clear) begin
        sticky_err      <= 1'b0;
        check_count     <= '0;
        err_count       <= '0;
        first_err_cmd   <= '0;
        first_err_exp   <= '0;
        first_err_got   <= '0;
        first_err_flags <= '0;
      end else if (s1_valid && legal) begin
        if (check_count != '1) check_count <= check_count + CNT_ONE;
        if (mismatch) begin
          if (err_count != '1) err_count <= err_count + CNT_ONE;
          if (!sticky_err) begin
            sticky_err      <= 1'b1;
            first_err_cmd   <= s1_cmd;
            first_err_exp   <= exp_res;
            first_err_got   <= s1_dut_out;
            first_err_flags <= {exp_flags, s1_dut_status};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: a default instance (CNT_W=16, C/V checked on logic ops)
// and a narrow instance (CNT_W=4, C/V masked on logic ops) driven with the same stimulus.
module tb_alu_result_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] val1 = '0;
  logic [31:0] val2 = '0;
  logic [3:0]  exe_cmd = '0;
  logic        c_in = 1'b0;
  logic [31:0] dut_out = '0;
  logic [3:0]  dut_status = '0;

  logic        chk_valid, chk_pass, illegal_cmd, sticky_err;
  logic [15:0] check_count, err_count;
  logic [3:0]  first_err_cmd;
  logic [31:0] first_err_exp, first_err_got;
  logic [7:0]  first_err_flags;

  logic        chk_valid_m, chk_pass_m, illegal_cmd_m, sticky_err_m;
  logic [3:0]  check_count_m, err_count_m;
  logic [3:0]  first_err_cmd_m;
  logic [31:0] first_err_exp_m, first_err_got_m;
  logic [7:0]  first_err_flags_m;

  always #5 clk = ~clk;

  alu_result_checker dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .val1(val1), .val2(val2), .exe_cmd(exe_cmd), .c_in(c_in),
    .dut_out(dut_out), .dut_status(dut_status),
    .chk_valid(chk_valid), .chk_pass(chk_pass), .illegal_cmd(illegal_cmd),
    .sticky_err(sticky_err), .check_count(check_count), .err_count(err_count),
    .first_err_cmd(first_err_cmd), .first_err_exp(first_err_exp),
    .first_err_got(first_err_got), .first_err_flags(first_err_flags)
  );

  alu_result_checker #(.WIDTH(32), .CNT_W(4), .CHECK_CV_LOGIC(1'b0)) dut_m (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .val1(val1), .val2(val2), .exe_cmd(exe_cmd), .c_in(c_in),
    .dut_out(dut_out), .dut_status(dut_status),
    .chk_valid(chk_valid_m), .chk_pass(chk_pass_m), .illegal_cmd(illegal_cmd_m),
    .sticky_err(sticky_err_m), .check_count(check_count_m), .err_count(err_count_m),
    .first_err_cmd(first_err_cmd_m), .first_err_exp(first_err_exp_m),
    .first_err_got(first_err_got_m), .first_err_flags(first_err_flags_m)
  );

  typedef struct {
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  cmd;
    logic        cin;
    logic [31:0] dout;
    logic [3:0]  dst;
    logic        pass_a;  // expected chk_pass on default instance
    logic        pass_b;  // expected chk_pass on C/V-masked instance
    logic        ill;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid   = 1'b1;
    val1       = v.v1;
    val2       = v.v2;
    exe_cmd    = v.cmd;
    c_in       = v.cin;
    dut_out    = v.dout;
    dut_status = v.dst;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  int   ca, ea, cb, eb;
  vec_t bad, mvn;

  initial begin
    vt[0]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0010, 1'b0, 32'hFFFFFFFE, 4'b1001, 1'b1, 1'b1, 1'b0};
    vt[1]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0100, 1'b0, 32'h00000000, 4'b0110, 1'b1, 1'b1, 1'b0};
    vt[2]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0101, 1'b1, 32'h00000000, 4'b0110, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0011, 1'b1, 32'hFFFFFFFF, 4'b1001, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{32'h00000000, 32'h7FFFFFFF, 4'b1001, 1'b0, 32'h80000000, 4'b1010, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 4'b0110, 1'b0, 32'h00F000F1, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{32'h00000001, 32'h00000002, 4'b1111, 1'b0, 32'h00000003, 4'b0000, 1'b0, 1'b0, 1'b1};
    vt[7]  = '{32'h00000001, 32'h00000002, 4'b0000, 1'b0, 32'h00000003, 4'b0000, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{32'h00000000, 32'h00000000, 4'b0111, 1'b0, 32'h00000000, 4'b0100, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000, 1'b0, 32'h00000000, 4'b0100, 1'b1, 1'b1, 1'b0};
    vt[10] = '{32'h00000000, 32'h00000001, 4'b0100, 1'b0, 32'hFFFFFFFF, 4'b1000, 1'b1, 1'b1, 1'b0};
    vt[11] = '{32'h80000000, 32'h80000000, 4'b0010, 1'b0, 32'h00000000, 4'b0111, 1'b1, 1'b1, 1'b0};
    vt[12] = '{32'h12345678, 32'h00000000, 4'b0001, 1'b0, 32'h00000000, 4'b0101, 1'b0, 1'b1, 1'b0};
    vt[13] = '{32'h00000005, 32'h00000003, 4'b0101, 1'b0, 32'h00000001, 4'b0010, 1'b1, 1'b1, 1'b0};
    bad    = '{32'hFFFFFFFF, 32'h0000FFFF, 4'b0110, 1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b0};
    mvn    = vt[4];

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_chk_valid", 64'(chk_valid), 64'd0);
    chk("rst_check_count", 64'(check_count), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_sticky", 64'(sticky_err), 64'd0);
    chk("rst_first_flags", 64'(first_err_flags), 64'd0);
    rst = 1'b1;

    // table: outputs for vector i appear two negedges after it is driven
    ca = 0; ea = 0; cb = 0; eb = 0;
    for (int i = 0; i < NV + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        if (!vt[i-2].ill) begin
          ca++;
          if (!vt[i-2].pass_a) ea++;
          if (cb < 15) cb++;
          if (!vt[i-2].pass_b && eb < 15) eb++;
        end
        chk($sformatf("v%0d_chk_valid", i-2), 64'(chk_valid), 64'd1);
        chk($sformatf("v%0d_chk_pass", i-2), 64'(chk_pass), 64'(vt[i-2].pass_a));
        chk($sformatf("v%0d_illegal", i-2), 64'(illegal_cmd), 64'(vt[i-2].ill));
        chk($sformatf("v%0d_check_count", i-2), 64'(check_count), 64'(ca));
        chk($sformatf("v%0d_err_count", i-2), 64'(err_count), 64'(ea));
        chk($sformatf("v%0d_m_chk_pass", i-2), 64'(chk_pass_m), 64'(vt[i-2].pass_b));
        chk($sformatf("v%0d_m_check_count", i-2), 64'(check_count_m), 64'(cb));
        chk($sformatf("v%0d_m_err_count", i-2), 64'(err_count_m), 64'(eb));
      end
      if (i < NV) drive(vt[i]);
      else idle();
    end

    // first-failure capture: MVN on default instance, bad AND on masked instance
    chk("cap_sticky", 64'(sticky_err), 64'd1);
    chk("cap_cmd", 64'(first_err_cmd), 64'h9);
    chk("cap_exp", 64'(first_err_exp), 64'h80000000);
    chk("cap_got", 64'(first_err_got), 64'h80000000);
    chk("cap_flags", 64'(first_err_flags), 64'h8A);
    chk("cap_m_cmd", 64'(first_err_cmd_m), 64'h6);
    chk("cap_m_exp", 64'(first_err_exp_m), 64'h00F000F0);
    chk("cap_m_got", 64'(first_err_got_m), 64'h00F000F1);
    chk("cap_m_flags", 64'(first_err_flags_m), 64'h00);
    @(negedge clk);
    chk("bubble_chk_valid", 64'(chk_valid), 64'd0);
    chk("bubble_chk_pass", 64'(chk_pass), 64'd0);
    chk("bubble_illegal", 64'(illegal_cmd), 64'd0);

    // saturation on the 4-bit instance
    repeat (20) begin
      @(negedge clk);
      drive(bad);
    end
    @(negedge clk); idle();
    @(negedge clk);
    chk("sat_m_err_count", 64'(err_count_m), 64'hF);
    chk("sat_m_check_count", 64'(check_count_m), 64'hF);
    chk("sat_err_count", 64'(err_count), 64'd23);
    chk("sat_check_count", 64'(check_count), 64'd32);
    chk("sat_cap_cmd_held", 64'(first_err_cmd), 64'h9);

    // clear at the edge where a mismatch completes; a passing txn is in stage 1 meanwhile
    drive(bad);
    @(negedge clk);
    clear = 1'b1;
    drive(vt[0]);
    @(negedge clk);
    chk("clr_chk_valid", 64'(chk_valid), 64'd1);
    chk("clr_chk_pass", 64'(chk_pass), 64'd0);
    clear = 1'b0;
    idle();
    chk("clr_err_count", 64'(err_count), 64'd0);
    chk("clr_check_count", 64'(check_count), 64'd0);
    chk("clr_sticky", 64'(sticky_err), 64'd0);
    chk("clr_cap_cmd", 64'(first_err_cmd), 64'd0);
    chk("clr_cap_flags", 64'(first_err_flags), 64'd0);
    chk("clr_m_err_count", 64'(err_count_m), 64'd0);
    chk("clr_m_sticky", 64'(sticky_err_m), 64'd0);
    @(negedge clk);
    chk("post_clr_chk_valid", 64'(chk_valid), 64'd1);
    chk("post_clr_chk_pass", 64'(chk_pass), 64'd1);
    chk("post_clr_check_count", 64'(check_count), 64'd1);
    chk("post_clr_m_check_count", 64'(check_count_m), 64'd1);
    chk("post_clr_err_count", 64'(err_count), 64'd0);

    // back-to-back stream, reset pulled low after the third transaction
    drive(mvn);
    @(negedge clk); drive(mvn);
    @(negedge clk); drive(mvn);
    @(negedge clk);
    chk("pre_rst_sticky", 64'(sticky_err), 64'd1);
    drive(mvn);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_chk_valid", 64'(chk_valid), 64'd0);
    chk("mid_rst_chk_pass", 64'(chk_pass), 64'd0);
    chk("mid_rst_sticky", 64'(sticky_err), 64'd0);
    chk("mid_rst_err_count", 64'(err_count), 64'd0);
    chk("mid_rst_check_count", 64'(check_count), 64'd0);
    chk("mid_rst_cap_exp", 64'(first_err_exp), 64'd0);
    @(negedge clk); drive(mvn);
    @(negedge clk);
    idle();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_chk_valid_%0d", k), 64'(chk_valid), 64'd0);
      chk($sformatf("post_rst_check_count_%0d", k), 64'(check_count), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
